// File: rtl/shim_ads816x_adc_timing_calc_gen.sv
// Runtime-selectable ADS8168/7/6 minimum n_cs high-time calculator. It uses a fixed-latency
// serial shift-add multiplier, validates the configuration and reports errors.
module shim_ads816x_adc_timing_calc_gen #(
    parameter int unsigned FREQ_WIDTH         = 32,
    parameter int unsigned OUT_WIDTH          = 8,
    parameter int unsigned CMD_BITS           = 16,
    parameter int unsigned MIN_CS_HIGH_CYCLES = 3,
    parameter int unsigned MAX_SPI_CLK_HZ     = 50_000_000
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [FREQ_WIDTH-1:0] spi_clk_freq_hz_i,
    input  logic [1:0]            model_sel_i,
    input  logic                  calc_i,
    output logic                  ready_o,
    output logic [OUT_WIDTH-1:0]  n_cs_high_time_o,
    output logic                  done_o,
    output logic                  saturated_o,
    output logic                  lock_viol_o,
    output logic                  cfg_err_o
);
    localparam int unsigned AW = FREQ_WIDTH + 16;
    localparam int unsigned CW = AW - 29;

    typedef enum logic [2:0] {StIdle, StMulConv, StMulCyc, StResult, StDone, StErr} state_e;

    state_e                state_q, state_d;
    logic [FREQ_WIDTH-1:0] freq_q, freq_d;
    logic [1:0]            model_q, model_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [AW-1:0]         acc_q, acc_d, mcand_q, mcand_d;
    logic [12:0]           mplier_q, mplier_d;
    logic [CW-1:0]         conv_q, conv_d, cyc_q, cyc_d;
    logic [OUT_WIDTH-1:0]  out_q, out_d;
    logic                  sat_q, sat_d, lock_q, lock_d, cfg_q, cfg_d;

    logic          cfg_bad, lock_bad, active;
    logic [12:0]   t_conv, t_cyc;
    logic [CW-1:0] ceil_val, res;

    assign cfg_bad  = (model_sel_i == 2'd3) || (spi_clk_freq_hz_i == '0) ||
                      (64'(spi_clk_freq_hz_i) > 64'(MAX_SPI_CLK_HZ));
    assign lock_bad = (spi_clk_freq_hz_i != freq_q) || (model_sel_i != model_q);
    assign active   = calc_i && !lock_bad;
    // ceil(acc / 2^30), with one spare bit so the rounding add cannot overflow
    assign ceil_val = CW'(({1'b0, acc_q} + (AW + 1)'(30'h3FFF_FFFF)) >> 30);
    assign res      = (conv_q > cyc_q) ? conv_q : cyc_q;

    // Conversion and cycle times in units of 2^-30 s
    always_comb begin
        unique case (model_q)
            2'd0:    begin t_conv = 13'd709;  t_cyc = 13'd1074; end
            2'd1:    begin t_conv = 13'd1289; t_cyc = 13'd2148; end
            2'd2:    begin t_conv = 13'd2685; t_cyc = 13'd4295; end
            default: begin t_conv = 13'd0;    t_cyc = 13'd0;    end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (calc_i) state_d = cfg_bad ? StErr : StMulConv;
            StMulConv, StMulCyc, StResult, StDone: begin
                if (lock_bad) begin
                    state_d = StErr;
                end else if (!calc_i) begin
                    state_d = StIdle;
                end else if (state_q == StMulConv && cnt_q == 4'd14) begin
                    state_d = StMulCyc;
                end else if (state_q == StMulCyc && cnt_q == 4'd13) begin
                    state_d = StResult;
                end else if (state_q == StResult) begin
                    state_d = StDone;
                end
            end
            StErr:   if (!calc_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ready_o          = (state_q == StIdle);
        done_o           = (state_q == StDone);
        saturated_o      = (state_q == StDone) && sat_q;
        lock_viol_o      = (state_q == StErr) && lock_q;
        cfg_err_o        = (state_q == StErr) && cfg_q;
        n_cs_high_time_o = out_q;
    end

    always_comb begin
        freq_d   = freq_q;
        model_d  = model_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        conv_d   = conv_q;
        cyc_d    = cyc_q;
        out_d    = out_q;
        sat_d    = sat_q;
        lock_d   = lock_q;
        cfg_d    = cfg_q;
        if (state_q inside {StMulConv, StMulCyc, StResult, StDone} && lock_bad) begin
            lock_d = 1'b1;
            cfg_d  = 1'b0;
        end
        unique case (state_q)
            StIdle: begin
                cnt_d = 4'd0;
                if (calc_i) begin
                    freq_d  = spi_clk_freq_hz_i;
                    model_d = model_sel_i;
                    cfg_d   = cfg_bad;
                    lock_d  = 1'b0;
                end
            end
            StMulConv: if (active) begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd0) begin
                    acc_d    = '0;
                    mcand_d  = AW'(freq_q);
                    mplier_d = t_conv;
                end else if (cnt_q == 4'd14) begin
                    conv_d   = (ceil_val < CW'(MIN_CS_HIGH_CYCLES)) ?
                               CW'(MIN_CS_HIGH_CYCLES) : ceil_val;
                    acc_d    = '0;
                    mcand_d  = AW'(freq_q);
                    mplier_d = t_cyc;
                    cnt_d    = 4'd0;
                end else begin
                    acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end
            end
            StMulCyc: if (active) begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd13) begin
                    cyc_d = (ceil_val > CW'(CMD_BITS)) ? ceil_val - CW'(CMD_BITS) : '0;
                end else begin
                    acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end
            end
            StResult: if (active) begin
                if (32'(res) > (32'd1 << OUT_WIDTH)) begin
                    out_d = '1;
                    sat_d = 1'b1;
                end else begin
                    out_d = OUT_WIDTH'(res - CW'(1));
                    sat_d = 1'b0;
                end
            end
            StErr: if (!calc_i) begin
                lock_d = 1'b0;
                cfg_d  = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            freq_q   <= '0;
            model_q  <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            conv_q   <= '0;
            cyc_q    <= '0;
            out_q    <= '0;
            sat_q    <= 1'b0;
            lock_q   <= 1'b0;
            cfg_q    <= 1'b0;
        end else begin
            freq_q   <= freq_d;
            model_q  <= model_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            conv_q   <= conv_d;
            cyc_q    <= cyc_d;
            out_q    <= out_d;
            sat_q    <= sat_d;
            lock_q   <= lock_d;
            cfg_q    <= cfg_d;
        end
    end

endmodule

// File: tb/tb_shim_ads816x_adc_timing_calc_gen.sv
// Randomized bench for the ADS816x n_cs timing calculator. It checks an 8-bit and a 7-bit
// output instance against an arithmetic reference model.
module tb_shim_ads816x_adc_timing_calc_gen;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] freq;
    logic [1:0]  sel;
    logic        calc;

    logic       rdy8, done8, sat8, lock8, cfg8;
    logic [7:0] n8;
    logic       rdy7, done7, sat7, lock7, cfg7;
    logic [6:0] n7;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint exp_n8   = 0;
    longint exp_n7   = 0;

    always #5 clk = ~clk;

    shim_ads816x_adc_timing_calc_gen #(.OUT_WIDTH(8)) u_dut8 (
        .clk_i(clk), .reset_i(reset), .spi_clk_freq_hz_i(freq), .model_sel_i(sel),
        .calc_i(calc), .ready_o(rdy8), .n_cs_high_time_o(n8), .done_o(done8),
        .saturated_o(sat8), .lock_viol_o(lock8), .cfg_err_o(cfg8)
    );

    shim_ads816x_adc_timing_calc_gen #(.OUT_WIDTH(7)) u_dut7 (
        .clk_i(clk), .reset_i(reset), .spi_clk_freq_hz_i(freq), .model_sel_i(sel),
        .calc_i(calc), .ready_o(rdy7), .n_cs_high_time_o(n7), .done_o(done7),
        .saturated_o(sat7), .lock_viol_o(lock7), .cfg_err_o(cfg7)
    );

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint ceil_ns(input longint f, input longint t);
        return (f * t + (longint'(1) << 30) - 1) / (longint'(1) << 30);
    endfunction

    // Cycle count before the minus-one and the output clipping
    function automatic longint ref_res(input int m, input longint f);
        longint tconv, tcyc, conv, cy, cyc;
        case (m)
            0:       begin tconv = 709;  tcyc = 1074; end
            1:       begin tconv = 1289; tcyc = 2148; end
            default: begin tconv = 2685; tcyc = 4295; end
        endcase
        conv = ceil_ns(f, tconv);
        if (conv < 3) conv = 3;
        cy  = ceil_ns(f, tcyc);
        cyc = (cy > 16) ? cy - 16 : 0;
        return (conv > cyc) ? conv : cyc;
    endfunction

    task automatic ref_out(input longint res, input int w, output longint n, output longint s);
        if (res > (longint'(1) << w)) begin
            n = (longint'(1) << w) - 1;
            s = 1;
        end else begin
            n = res - 1;
            s = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_calc(input int m, input longint f);
        longint res, e8, s8, e7, s7;
        int     early;
        bit     illegal;
        illegal = (m == 3) || (f == 0) || (f > 50_000_000);
        sel  = 2'(m);
        freq = 32'(f);
        calc = 1'b1;
        tick();
        if (illegal) begin
            check_eq("cfg_err_set", cfg8, 1);
            check_eq("cfg_lock_clr", lock8, 0);
            check_eq("cfg_ready", rdy8, 0);
            check_eq("cfg_done", done8, 0);
            check_eq("cfg_n_hold", n8, exp_n8);
        end else begin
            res = ref_res(m, f);
            ref_out(res, 8, e8, s8);
            ref_out(res, 7, e7, s7);
            check_eq("busy_ready", rdy8, 0);
            early = 0;
            for (int e = 1; e < 30; e++) begin
                tick();
                if (done8 || done7) early++;
            end
            check_eq("done_early", early, 0);
            tick();
            check_eq("done8", done8, 1);
            check_eq("done7", done7, 1);
            check_eq("n8", n8, e8);
            check_eq("sat8", sat8, s8);
            check_eq("n7", n7, e7);
            check_eq("sat7", sat7, s7);
            exp_n8 = e8;
            exp_n7 = e7;
        end
        calc = 1'b0;
        tick();
        check_eq("idle_ready", rdy8, 1);
        check_eq("idle_done", done8, 0);
        check_eq("idle_cfg", cfg8, 0);
        check_eq("idle_n_hold", n8, exp_n8);
    endtask

    // Starts a legal calculation and changes the live inputs after k edges past the sample
    task automatic run_lock(input int m, input longint f, input int k, input int new_m,
                            input longint new_f);
        sel  = 2'(m);
        freq = 32'(f);
        calc = 1'b1;
        tick();
        repeat (k) tick();
        sel  = 2'(new_m);
        freq = 32'(new_f);
        tick();
        check_eq("lock_set", lock8, 1);
        check_eq("lock_cfg", cfg8, 0);
        check_eq("lock_done", done8, 0);
        check_eq("lock_ready", rdy8, 0);
        check_eq("lock_n8_hold", n8, exp_n8);
        check_eq("lock_n7_hold", n7, exp_n7);
        tick();
        check_eq("lock_held", lock8, 1);
        calc = 1'b0;
        tick();
        check_eq("lock_clr", lock8, 0);
        check_eq("lock_ready_back", rdy8, 1);
    endtask

    initial begin
        int     kind, m, k;
        longint f;
        reset = 1'b1;
        calc  = 1'b0;
        sel   = 2'd0;
        freq  = 32'd0;
        #2;
        check_eq("rst_ready", rdy8, 1);
        check_eq("rst_n", n8, 0);
        check_eq("rst_done", done8, 0);
        check_eq("rst_flags", {sat8, lock8, cfg8}, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        run_calc(0, 50_000_000);
        check_eq("t1_n", n8, 34);
        run_calc(2, 50_000_000);
        check_eq("t2_n8", n8, 184);
        check_eq("t2_n7", n7, 127);
        run_calc(0, 1_000_000);
        check_eq("t3_n", n8, 2);
        run_lock(0, 50_000_000, 4, 0, 25_000_000);
        run_calc(3, 50_000_000);
        run_calc(0, 60_000_000);
        run_calc(1, 0);
        run_calc(2, 50_000_001);
        run_calc(2, 50_000_000);

        // Asynchronous reset partway through the cycle-time multiply
        sel  = 2'd2;
        freq = 32'd50_000_000;
        calc = 1'b1;
        tick();
        repeat (20) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check_eq("arst_ready", rdy8, 1);
        check_eq("arst_n", n8, 0);
        check_eq("arst_done", done8, 0);
        check_eq("arst_flags", {sat8, lock8, cfg8}, 0);
        exp_n8 = 0;
        exp_n7 = 0;
        calc = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tick();
        run_calc(1, 50_000_000);
        check_eq("t6_n", n8, 84);

        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 99));
            m    = int'($urandom_range(0, 2));
            case ($urandom_range(0, 3))
                0:       f = 50_000_000;
                1:       f = longint'($urandom_range(1, 2_000_000));
                default: f = longint'($urandom_range(1, 50_000_000));
            endcase
            if (kind < 65) begin
                run_calc(m, f);
            end else if (kind < 80) begin
                case ($urandom_range(0, 2))
                    0:       run_calc(3, f);
                    1:       run_calc(m, 0);
                    default: run_calc(m, 50_000_001 + longint'($urandom_range(0, 100_000_000)));
                endcase
            end else begin
                k = int'($urandom_range(0, 29));
                if ($urandom_range(0, 1) == 0) run_lock(m, f, k, (m + 1) % 3, f);
                else run_lock(m, f, k, m, (f == 1) ? 2 : f - 1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shim_ads816x_adc_timing_calc_gen.md
Name: shim_ads816x_adc_timing_calc_gen

Overview:
- Runtime-configurable successor to the single-model ADS816x n_cs timing calculator.
- Computes the minimum n_cs high time, in SPI clock cycles minus 1, for ADS8168, ADS8167 or ADS8166, selected at run time by model_sel.
- Uses a fixed-latency serial shift-add multiplier. Output width, command length and minimum high time are parameters.
- Adds configuration validation, sticky error reporting, saturation flagging and a ready indication. Sits between the SPI clock configuration registers and the ADC SPI sequencer.

Parameters:
- FREQ_WIDTH, 32: width of spi_clk_freq_hz.
- OUT_WIDTH, 8: width of n_cs_high_time (range 4..16).
- CMD_BITS, 16: SPI command bits that count toward t_cycle.
- MIN_CS_HIGH_CYCLES, 3: lower clamp on the conversion-derived cycle count.
- MAX_SPI_CLK_HZ, 50_000_000: highest legal SPI clock frequency.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- spi_clk_freq_hz  in  FREQ_WIDTH  SPI clock frequency in Hz
- model_sel  in  2  0=ADS8168, 1=ADS8167, 2=ADS8166, 3=illegal
- calc  in  1  level request; hold high until done or error is seen
- ready  out  1  high in IDLE
- n_cs_high_time  out  OUT_WIDTH  result: cycles minus 1
- done  out  1  result valid; held while calc stays high
- saturated  out  1  result clipped to all-ones
- lock_viol  out  1  freq or model_sel changed mid-calculation
- cfg_err  out  1  illegal model, frequency of zero, or frequency above MAX_SPI_CLK_HZ

Behaviour:
- Reset values: all outputs 0 except ready=1; state=IDLE; all internal registers cleared. Reset is asynchronous and may abort any state.
- Constants, in NiS units (2^30 NiS = 1 s), as conversion time / cycle time:
  - model 0: 709 / 1074
  - model 1: 1289 / 2148
  - model 2: 2685 / 4295
- States: IDLE, MUL_CONV, MUL_CYC, RESULT, DONE, ERR.
- IDLE:
  - ready=1; done, saturated, lock_viol and cfg_err are 0.
  - When calc=1 on an edge, latch freq and model_sel, then go to ERR if the configuration is illegal, otherwise to MUL_CONV.
- Multiplier: 13-bit constant × FREQ_WIDTH-bit frequency into a (FREQ_WIDTH+16)-bit accumulator.
  - Exactly 13 accumulate cycles per multiply, regardless of model, so latency is fixed.
  - One finalize cycle follows each multiply.
- Rounding: ceil(x / 2^30) = (acc + 2^30 − 1) >> 30.
- conv_cyc = max(ceil(f·Tconv), MIN_CS_HIGH_CYCLES).
- cyc_cyc = ceil(f·Tcycle) > CMD_BITS ? ceil(f·Tcycle) − CMD_BITS : 0.
- RESULT: res = max(conv_cyc, cyc_cyc).
- DONE, on entry:
  - If res > 2^OUT_WIDTH: n_cs_high_time = all-ones and saturated=1.
  - Otherwise n_cs_high_time = res − 1 and saturated=0.
  - done=1 and stays 1 while calc=1.
- Latency: done is first high on the 30th rising edge after the edge that sampled calc=1 in IDLE (1 latch, 14 MUL_CONV, 14 MUL_CYC, 1 RESULT).
- n_cs_high_time holds its last value until overwritten by the next successful calculation. It is not cleared by a later error.
- Lock check, in MUL_CONV, MUL_CYC, RESULT and DONE:
  - If the live freq or model_sel differs from the latched value, go to ERR with lock_viol=1.
  - Lock check has priority over calc deassertion.
- calc deasserted in MUL_CONV, MUL_CYC, RESULT or DONE: go to IDLE; done is cleared on that edge; no error is flagged.
- ERR:
  - lock_viol or cfg_err (whichever caused entry) is held high; ready=0, done=0.
  - Go to IDLE on the first edge with calc=0; the flags are cleared on that edge.
- Simultaneous illegal configuration and calc assertion: cfg_err wins; lock_viol=0.
- calc re-asserted on the same edge that returns to IDLE is ignored until the next edge.

Test Plan:
1. model_sel=0, f=50_000_000, calc held high -> conv=34, cyc=51−16=35; n_cs_high_time=34, done=1 exactly 30 edges after the calc sample, saturated=0.
2. model_sel=2, f=50_000_000 -> conv=126, cyc=201−16=185; n_cs_high_time=184. Same stimulus on an OUT_WIDTH=7 instance -> n_cs_high_time=127, saturated=1.
3. model_sel=0, f=1_000_000 -> conv=1 clamped to 3, cyc=2−16 floored to 0; n_cs_high_time=2.
4. Change f from 50_000_000 to 25_000_000 on the 5th MUL_CONV cycle -> lock_viol=1, done stays 0, n_cs_high_time unchanged. Drop calc -> lock_viol=0, ready=1 one edge later.
5. model_sel=3, or f=60_000_000, or f=0, with calc high -> cfg_err=1 one edge after the sample; no multiply is run; cleared after calc goes low.
6. Assert reset asynchronously mid-MUL_CYC -> all outputs return to reset values immediately. Deassert calc in DONE -> done=0 next edge; a fresh calc with model_sel=1, f=50_000_000 -> n_cs_high_time=84 (conv 61, cyc 101−16=85).
